// File: rtl/tnn_pkg.sv
// tnn_pkg: shared widths and sequencer state encoding for the TNN operand interface
package tnn_pkg;
  localparam int FEAT_W = 3;
  localparam int N_FEAT = 5;
  typedef enum logic [1:0] {COLLECT, DRAIN, EVAL, EMIT} tnn_seq_state_t;
endpackage

// File: rtl/tnn_operand_bank.sv
// tnn_operand_bank: N_FEAT operand lane registers with indexed write and zero-fill
// Ports: clk/rst_n, we writes din to lane idx; with zero_fill, lanes above idx clear
// in the same cycle; lanes drives the neuron operand inputs.
module tnn_operand_bank #(
  parameter int FEAT_W = tnn_pkg::FEAT_W,
  parameter int N_FEAT = tnn_pkg::N_FEAT,
  parameter int IW = $clog2(N_FEAT + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          we,
  input  logic                          zero_fill,
  input  logic [IW-1:0]                 idx,
  input  logic [FEAT_W-1:0]             din,
  output logic [N_FEAT-1:0][FEAT_W-1:0] lanes
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lanes <= '0;
    else if (we)
      for (int i = 0; i < N_FEAT; i++)
        if (i == int'(idx)) lanes[i] <= din;
        else if (zero_fill && i > int'(idx)) lanes[i] <= '0;
endmodule

// File: rtl/tnn_feature_sequencer.sv
// tnn_feature_sequencer: assembles feature beats into neuron operands and emits one decision per sample
// Ports: s_* feature stream in (valid/ready/last), nrn_a..nrn_e operand lanes and
// nrn_out decision from the combinational neuron, m_* decision stream out with
// error flag and sample index, pos_cnt saturating count of emitted positive decisions.
module tnn_feature_sequencer #(
  parameter int FEAT_W   = tnn_pkg::FEAT_W,
  parameter int N_FEAT   = tnn_pkg::N_FEAT,
  parameter int EVAL_CYC = 1,
  parameter int IDX_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [FEAT_W-1:0] s_data,
  input  logic              s_last,
  output logic [FEAT_W-1:0] nrn_a,
  output logic [FEAT_W-1:0] nrn_b,
  output logic [FEAT_W-1:0] nrn_c,
  output logic [FEAT_W-1:0] nrn_d,
  output logic [FEAT_W-1:0] nrn_e,
  input  logic              nrn_out,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_data,
  output logic              m_err,
  output logic [IDX_W-1:0]  m_idx,
  output logic [IDX_W-1:0]  pos_cnt
);
  import tnn_pkg::*;
  localparam int CW = $clog2(N_FEAT + 1);
  tnn_seq_state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [3:0] ev_cnt;
  logic err, acc, hs, last_feat, ev_done;
  logic [N_FEAT-1:0][FEAT_W-1:0] lanes;
  // s_ready depends only on registered state, so m_ready never reaches it combinationally
  assign s_ready = state == COLLECT || state == DRAIN;
  assign acc = s_valid && s_ready;
  assign hs = m_valid && m_ready;
  assign last_feat = cnt == CW'(N_FEAT - 1);
  assign ev_done = ev_cnt == 4'(EVAL_CYC - 1);
  tnn_operand_bank #(.FEAT_W(FEAT_W), .N_FEAT(N_FEAT), .IW(CW)) u_bank (
    .clk(clk), .rst_n(rst_n), .we(state == COLLECT && acc), .zero_fill(s_last),
    .idx(cnt), .din(s_data), .lanes(lanes)
  );
  assign {nrn_e, nrn_d, nrn_c, nrn_b, nrn_a} = lanes;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= COLLECT;
    else state <= nxt;
  always_comb begin
    nxt = state;
    unique case (state)
      COLLECT: nxt = !acc ? COLLECT : s_last ? EVAL : last_feat ? DRAIN : COLLECT;
      DRAIN:   nxt = acc && s_last ? EVAL : DRAIN;
      EVAL:    nxt = ev_done ? EMIT : EVAL;
      EMIT:    nxt = hs ? COLLECT : EMIT;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      err <= 1'b0;
      ev_cnt <= '0;
      m_valid <= 1'b0;
      m_data <= 1'b0;
      m_err <= 1'b0;
      m_idx <= '0;
      pos_cnt <= '0;
    end else begin
      ev_cnt <= state == EVAL ? ev_cnt + 4'd1 : 4'd0;
      // a sample is well-formed only when s_last lands exactly on the final lane
      if (state == COLLECT && acc) begin
        cnt <= cnt + CW'(1);
        err <= s_last != last_feat;
      end
      if (state == EVAL && ev_done) begin
        m_valid <= 1'b1;
        m_data <= nrn_out;
        m_err <= err;
      end
      if (hs) begin
        m_valid <= 1'b0;
        m_idx <= m_idx + IDX_W'(1);
        pos_cnt <= m_data && !(&pos_cnt) ? pos_cnt + IDX_W'(1) : pos_cnt;
        cnt <= '0;
        err <= 1'b0;
      end
    end
endmodule
